// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the sequential radix-2 Booth multiplier.
//   booth_state_t : controller state (IDLE/ARITH/SHIFT/DONE), 2-bit encoding
//   booth_op_t    : datapath operation applied to the partial remainder A
//   cnt_width()   : width of the step counter, sized to hold WIDTH
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARITH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } booth_state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_ctrl.sv
// booth_ctrl: FSM and step counter for the sequential Booth multiplier.
// All state updates on the falling edge of clk; rst is asynchronous, active-low.
// Ports:
//   clk, rst  : clock (falling-edge active) and async active-low reset
//   start     : request, honoured only in IDLE
//   y_lsb     : multiplier LSB presented on the accepting edge
//   q_lo      : current Q[1:0] of the datapath
//   q_m1      : current Booth history bit
//   ld        : load operands this edge (accept)
//   op        : add/sub/none applied to A this edge
//   shift     : arithmetic right shift of {A,Q,q_m1} this edge
//   cap_prod  : capture the product this edge (final shift)
//   done      : high for the single cycle spent in DONE
//   state     : current FSM state (debug visibility)
// Optional feature: BOOTH_SKIP_ARITH_EN lets the FSM bypass ARITH when the
// upcoming Booth pair is 00 or 11, giving operand-dependent latency.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         y_lsb,
  input  logic [1:0]   q_lo,
  input  logic         q_m1,
  output logic         ld,
  output booth_op_t    op,
  output logic         shift,
  output logic         cap_prod,
  output logic         done,
  output booth_state_t state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  booth_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

`ifndef BOOTH_SKIP_ARITH_EN
  // Skip-decision inputs only matter when the bypass feature is built in.
  logic unused_skip;
  assign unused_skip = y_lsb ^ q_lo[1];
`endif

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld       = 1'b0;
    op       = OP_NONE;
    shift    = 1'b0;
    cap_prod = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ld    = 1'b1;
          cnt_d = '0;
`ifdef BOOTH_SKIP_ARITH_EN
          // First pair is {y[0], 0}: only y[0]=1 needs a subtract.
          state_d = y_lsb ? ARITH : SHIFT;
`else
          state_d = ARITH;
`endif
        end
      end
      ARITH: begin
        unique case ({q_lo[0], q_m1})
          2'b10:   op = OP_SUB;
          2'b01:   op = OP_ADD;
          default: op = OP_NONE;
        endcase
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cap_prod = 1'b1;
          state_d  = DONE;
        end else begin
`ifdef BOOTH_SKIP_ARITH_EN
          // After the shift the pair becomes {Q[1], Q[0]}.
          state_d = (q_lo[1] ^ q_lo[0]) ? ARITH : SHIFT;
`else
          state_d = ARITH;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed radix-2 Booth multiplier.
// One Booth step costs an ARITH edge plus a SHIFT edge; all state updates on
// the falling edge of clk; rst is asynchronous and active-low.
// Ports:
//   clk, rst : clock (falling-edge active), async active-low reset
//   start    : request; accepted on an edge where ready=1
//   x_in     : signed multiplicand, sampled on the accepting edge only
//   y_in     : signed multiplier, sampled on the accepting edge only
//   ready    : high only in IDLE
//   busy     : !ready
//   done     : one-cycle pulse while in DONE
//   prod     : signed 2*WIDTH-bit product, held until the next result lands
// Handshake: a request is taken on the clock edge where start=1 and ready=1;
// start while not ready is dropped (no queueing). done marks the single cycle
// in which a freshly captured prod is first visible.
// Optional feature: BOOTH_SKIP_ARITH_EN (see booth_ctrl) shortens latency.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x_in,
  input  logic [WIDTH-1:0]     y_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  // A and M carry one guard bit so that subtracting -2^(WIDTH-1) cannot overflow.
  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH-1:0] q_q;
  logic             q_m1_q;

  logic         ld;
  booth_op_t    op;
  logic         shift;
  logic         cap_prod;
  booth_state_t state;

  booth_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .y_lsb    (y_in[0]),
    .q_lo     (q_q[1:0]),
    .q_m1     (q_m1_q),
    .ld       (ld),
    .op       (op),
    .shift    (shift),
    .cap_prod (cap_prod),
    .done     (done),
    .state    (state)
  );

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      m_q    <= '0;
      q_q    <= '0;
      q_m1_q <= 1'b0;
      prod   <= '0;
    end else begin
      if (ld) begin
        m_q    <= {x_in[WIDTH-1], x_in};
        q_q    <= y_in;
        a_q    <= '0;
        q_m1_q <= 1'b0;
      end else if (shift) begin
        {a_q, q_q, q_m1_q} <= {a_q[WIDTH], a_q, q_q};
        // Low WIDTH bits of shifted A followed by shifted Q reduce to {A, Q[W-1:1]}.
        if (cap_prod) begin
          prod <= {a_q, q_q[WIDTH-1:1]};
        end
      end else if (op == OP_ADD) begin
        a_q <= a_q + m_q;
      end else if (op == OP_SUB) begin
        a_q <= a_q - m_q;
      end
    end
  end

  assign ready = (state == IDLE);
  assign busy  = !ready;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed and random checks of booth_mult_seq (WIDTH=8).
module tb_booth_mult_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   x_in = '0;
  logic [W-1:0]   y_in = '0;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] prod;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  // ---------------- scoreboard / reference ----------------
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] xs;
    logic signed [2*W-1:0] ys;
    xs = {{W{x[W-1]}}, x};
    ys = {{W{y[W-1]}}, y};
    return xs * ys;
  endfunction

  // Edges from the accepting edge to the edge that enters DONE.
  function automatic int ref_lat(input logic [W-1:0] y);
`ifdef BOOTH_SKIP_ARITH_EN
    int   n;
    logic prev;
    n    = W;
    prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (y[i] != prev) n++;
      prev = y[i];
    end
    return n;
`else
    return 2 * W;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Raise start with operands; returns number of falling edges until accepted.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, output int waited);
    logic r;
    x_in   = x;
    y_in   = y;
    start  = 1'b1;
    waited = 0;
    r      = 1'b0;
    while (waited < 50) begin
      @(posedge clk);
      r = ready;
      @(negedge clk);
      waited++;
      if (r) break;
    end
    #1;
    start = 1'b0;
    x_in  = W'($urandom);
    y_in  = W'($urandom);
    check("accept", {31'b0, r}, 32'd1);
  endtask

  // Count edges after accept until done is seen; optionally pulse start mid-run.
  task automatic wait_done(input bit pulse, input logic [2*W-1:0] hold, output int edges);
    bit busy_ok;
    bit seen;
    edges   = 0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (edges < 100) begin
      @(negedge clk);
      edges++;
      #1;
      if (busy !== !ready) busy_ok = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (pulse) begin
        start = (edges == 2 || edges == 8);
        if (edges == 9) check("prod_hold_mid", {16'b0, prod}, {16'b0, hold});
      end
    end
    start = 1'b0;
    check("done_seen", {31'b0, seen}, 32'd1);
    check("busy_inv", {31'b0, busy_ok}, 32'd1);
  endtask

  // Full transaction: accept, latency, product, one-cycle done.
  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input bit pulse, input bit b2b);
    int waited;
    int edges;
    logic [2*W-1:0] hold;
    start_op(x, y, waited);
    hold = prod;
    exp_q.push_back(ref_prod(x, y));
    wait_done(pulse, hold, edges);
    check("latency", edges, ref_lat(y));
    check("prod", {16'b0, prod}, {16'b0, exp_q.pop_front()});
    if (!b2b) begin
      @(negedge clk);
      #1;
      check("done_fall", {31'b0, done}, 32'd0);
      check("ready_after", {31'b0, ready}, 32'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    logic [2*W-1:0] keep;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_prod", {16'b0, prod}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;

    // 7 * -3
    run(8'd7, 8'hFD, 1'b0, 1'b0);
    check("p_7x-3", {16'b0, prod}, 32'h0000FFEB);

    // reset mid-operation at edge 5 of a 7 * -3 run
    start_op(8'd7, 8'hFD, waited);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, ready}, 32'd1);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_prod", {16'b0, prod}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    run(8'd7, 8'hFD, 1'b0, 1'b0);

    // corner operands
    run(8'h80, 8'h80, 1'b0, 1'b0);
    check("p_min_min", {16'b0, prod}, 32'h00004000);
    run(8'h80, 8'h7F, 1'b0, 1'b0);
    check("p_min_max", {16'b0, prod}, 32'h0000C080);
    run(8'h00, 8'hFF, 1'b0, 1'b0);
    check("p_zero", {16'b0, prod}, 32'd0);

    // latency-shaping operands for the bypass build
    run(8'd5, 8'h00, 1'b0, 1'b0);
    run(8'd5, 8'hFF, 1'b0, 1'b0);
    check("p_5x-1", {16'b0, prod}, 32'h0000FFFB);

    // start pulses while busy are ignored; then back-to-back request
    keep = prod;
    run(8'd13, 8'hF6, 1'b1, 1'b1);
    check("prod_changed", {31'b0, prod != keep}, 32'd1);
    start_op(8'hE9, 8'd11, waited);
    check("b2b_wait", waited, 2);
    exp_q.push_back(ref_prod(8'hE9, 8'd11));
    begin
      int edges;
      wait_done(1'b0, prod, edges);
      check("b2b_latency", edges, ref_lat(8'd11));
      check("b2b_prod", {16'b0, prod}, {16'b0, exp_q.pop_front()});
    end
    @(negedge clk);
    #1;

    // random operands
    for (int i = 0; i < 24; i++) begin
      run(W'($urandom), W'($urandom_range(0, 255)), 1'b0, 1'b0);
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
